apb_bridge_nslv: RTL and testbench
==================================

Name: apb_bridge_nslv

Overview:
Parametrised APB master bridge, successor to the fixed 2-slave, 8-bit bridge. Accepts read/write commands on a valid/ready command port and runs APB SETUP/ACCESS phases toward NUM_SLAVES slaves. It decodes the slave from the upper address bits, supports back-to-back transfers, and ends hung transfers with a PREADY timeout. It returns a registered response with data, error and timeout flags.

Parameters:
NUM_SLAVES, 4, number of slaves; range 1..16
ADDR_W, 12, PADDR width
DATA_W, 32, PWDATA/PRDATA width; multiple of 8
TIMEOUT, 16, maximum ACCESS cycles waiting for PREADY; 0 disables the timeout

Ports:
PCLK  in  1  clock, rising edge
PRESETn  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  bridge can take a command
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  PSLVERR, decode error or timeout
rsp_timeout  out  1  error was caused by timeout
PSEL  out  NUM_SLAVES  one-hot slave select
PENABLE  out  1  ACCESS phase
PADDR  out  ADDR_W  registered address
PWRITE  out  1  registered direction
PWDATA  out  DATA_W  registered write data
PRDATA  in  NUM_SLAVES*DATA_W  flattened; slave i at [i*DATA_W +: DATA_W]
PREADY  in  NUM_SLAVES  per-slave ready
PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset: sampled only on the PCLK edge. While PRESETn=0 every output is 0, including cmd_ready, and the state is IDLE. Reset mid-transfer drops PSEL/PENABLE in the following cycle and produces no response.
- Decode: SEL_W = max(1, clog2(NUM_SLAVES)). The slave index is cmd_addr[ADDR_W-1 -: SEL_W]. An index >= NUM_SLAVES is unmapped. PADDR carries the full address.
- Handshake: a command is accepted when cmd_valid && cmd_ready. On acceptance, cmd_addr, cmd_write, cmd_wdata and the decoded index are registered into PADDR/PWRITE/PWDATA/sel.
- cmd_ready = PRESETn && (state==IDLE || completing), where completing means ACCESS with the selected PREADY=1 or the timeout firing.
- FSM IDLE: outputs idle. An accepted command goes to SETUP.
- FSM SETUP (exactly 1 cycle): PSEL[sel]=1, PENABLE=0, then go to ACCESS.
  - Unmapped address: PSEL stays all-zero and no bus activity occurs. The transfer completes at the end of SETUP with rsp_err=1 and the FSM returns to IDLE; a back-to-back accept is not taken here.
- FSM ACCESS: PSEL[sel]=1, PENABLE=1. Wait while PREADY[sel]=0.
  - Completion edge: PREADY[sel]=1. Capture rsp_rdata = PRDATA slice (reads only) and rsp_err = PSLVERR[sel].
  - Next state: SETUP if a new command is accepted on the same edge (back-to-back; PENABLE drops for that SETUP cycle), else IDLE with PSEL cleared.
- Timeout: a counter clears on entering ACCESS and increments on each ACCESS cycle with PREADY[sel]=0.
  - When the count reaches TIMEOUT and PREADY[sel] is still 0, the transfer completes with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY arriving on the same edge as the limit wins: normal completion, no timeout.
  - Counter width is clog2(TIMEOUT+1).
- Response: rsp_* are registered and valid for exactly one cycle, the cycle after the completion edge. rsp_rdata/rsp_err/rsp_timeout hold their values until the next response; rsp_valid returns to 0.
- Latency with zero wait states: accept at edge k, SETUP in cycle k+1, ACCESS in cycle k+2, completion at edge k+3, rsp_valid in cycle k+3. Peak throughput is one transfer per 2 cycles.
- PSEL/PENABLE glitch-free: all registered. Ignored inputs: PREADY/PSLVERR of unselected slaves, and all inputs during SETUP.

Decomposition:
- Package apb_nslv_pkg:
  - state enum {IDLE, SETUP, ACCESS}
  - function sel_width(n)
  - response struct {rdata, err, timeout}
- One sub-module, apb_addr_decode: combinational address to {index, unmapped}, parametrised by NUM_SLAVES and ADDR_W. It is reused by future slave-side muxes.

Test Plan:
(All tests use NUM_SLAVES=3, ADDR_W=12, DATA_W=32, TIMEOUT=16; slave index = addr[11:10].)
1. Zero-wait write 0x404 <- 0xDEADBEEF, then read 0x404 with slave 1 returning 0xDEADBEEF -> PSEL=3'b010, PWRITE 1 then 0; rsp_valid 3 cycles after each accept; read rsp_rdata=0xDEADBEEF, rsp_err=0.
2. Read 0x008 with slave 0 holding PREADY low for 5 ACCESS cycles -> PENABLE high for 6 cycles; rsp_valid in cycle accept+8; no timeout.
3. Back-to-back: cmd_valid held with writes to 0x000, 0x400, 0x800 -> no IDLE between transfers; PSEL sequence 001, 010, 100; three rsp_valid pulses spaced 2 cycles apart.
4. Unmapped read 0xC00 -> PSEL stays 0 and PENABLE never rises; rsp_err=1, rsp_timeout=0, rsp_rdata=0; returns to IDLE.
5. Slave 2 never asserts PREADY -> completion after 16 ACCESS cycles with rsp_err=1, rsp_timeout=1. Separately, slave 1 asserts PREADY exactly on the 16th cycle with PSLVERR=1 -> rsp_err=1, rsp_timeout=0.
6. PRESETn driven low for one edge during ACCESS of a read -> next cycle all APB outputs are 0, no rsp_valid; cmd_ready=0 during reset and 1 after; a new read then completes normally.

Source files
------------

// File: rtl/apb_nslv_pkg.sv
// Shared types for the N-slave APB bridge: FSM states, select-width helper
// and the registered response record.
package apb_nslv_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_e;

    // Widest data path a bridge instance may use; the response record is sized to it.
    localparam int unsigned MAX_DATA_W = 256;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } rsp_t;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave decode: the top SEL_W address bits pick the slave,
// indices at or above NUM_SLAVES are flagged unmapped.
module apb_addr_decode
    import apb_nslv_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned ADDR_W     = 12,
    localparam int unsigned SEL_W     = sel_width(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [SEL_W-1:0]  index,
    output logic              unmapped
);

    assign index    = addr[ADDR_W-1 -: SEL_W];
    assign unmapped = (32'(index) >= NUM_SLAVES);

    if (ADDR_W > SEL_W) begin : g_addr_lo
        logic unused_addr_lo;
        assign unused_addr_lo = ^addr[ADDR_W-SEL_W-1:0];
    end

endmodule

// File: rtl/apb_bridge_nslv.sv
// APB master bridge: valid/ready command port to NUM_SLAVES APB slaves with
// address decode, back-to-back transfers and a PREADY timeout.
module apb_bridge_nslv
    import apb_nslv_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [ADDR_W-1:0]            cmd_addr,
    input  logic [DATA_W-1:0]            cmd_wdata,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic                         rsp_timeout,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    output logic [ADDR_W-1:0]            PADDR,
    output logic                         PWRITE,
    output logic [DATA_W-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    localparam int unsigned SEL_W = sel_width(NUM_SLAVES);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    unmapped_q, unmapped_d;
    logic [ADDR_W-1:0]       paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_W-1:0]       pwdata_q, pwdata_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    rsp_valid_q, rsp_valid_d;
    rsp_t                    rsp_q, rsp_d;

    logic [SEL_W-1:0]        dec_index;
    logic                    dec_unmapped;
    logic [NUM_SLAVES-1:0]   dec_psel;
    logic [DATA_W-1:0]       prdata_slv [NUM_SLAVES];
    logic                    sel_ready;
    logic                    sel_err;
    logic                    timeout_hit;
    logic                    completing;
    logic                    accept;

    apb_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W)
    ) u_decode (
        .addr     (cmd_addr),
        .index    (dec_index),
        .unmapped (dec_unmapped)
    );

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_prdata
        assign prdata_slv[i] = PRDATA[i*DATA_W +: DATA_W];
    end

    assign dec_psel    = dec_unmapped ? '0 : (NUM_SLAVES'(1) << dec_index);
    assign sel_ready   = PREADY[sel_q];
    assign sel_err     = PSLVERR[sel_q];
    // PREADY on the limit cycle wins over the timeout.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST) && !sel_ready;
    assign completing  = (state_q == StAccess) && (sel_ready || timeout_hit);
    assign cmd_ready   = PRESETn && ((state_q == StIdle) || completing);
    assign accept      = cmd_valid && cmd_ready;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        unmapped_d  = unmapped_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_d       = rsp_q;

        if (accept) begin
            paddr_d    = cmd_addr;
            pwrite_d   = cmd_write;
            pwdata_d   = cmd_wdata;
            sel_d      = dec_index;
            unmapped_d = dec_unmapped;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StSetup;
                    psel_d    = dec_psel;
                    penable_d = 1'b0;
                end
            end
            StSetup: begin
                if (unmapped_q) begin
                    // Decode error: no bus activity, respond straight from SETUP.
                    state_d       = StIdle;
                    psel_d        = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b0;
                end else begin
                    state_d   = StAccess;
                    penable_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            StAccess: begin
                if (completing) begin
                    rsp_valid_d   = 1'b1;
                    rsp_d.timeout = timeout_hit;
                    rsp_d.err     = timeout_hit || sel_err;
                    rsp_d.rdata   = (!timeout_hit && !pwrite_q && !sel_err) ?
                                    MAX_DATA_W'(prdata_slv[sel_q]) : '0;
                    penable_d     = 1'b0;
                    if (accept) begin
                        state_d = StSetup;
                        psel_d  = dec_psel;
                    end else begin
                        state_d = StIdle;
                        psel_d  = '0;
                    end
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            unmapped_q  <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            unmapped_q  <= unmapped_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_q.rdata[DATA_W-1:0];
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

    if (DATA_W < MAX_DATA_W) begin : g_rdata_hi
        logic unused_rdata_hi;
        assign unused_rdata_hi = ^rsp_q.rdata[MAX_DATA_W-1:DATA_W];
    end

endmodule

// File: tb/tb_apb_bridge_nslv.sv
// Directed bench for apb_bridge_nslv: three modelled slaves with per-slave
// wait states, error and read data; cycle-indexed logs of the APB side.
module tb_apb_bridge_nslv;

    localparam int unsigned NS   = 3;
    localparam int unsigned AW   = 12;
    localparam int unsigned DW   = 32;
    localparam int unsigned TO   = 16;
    localparam int          LOGN = 1024;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [NS-1:0] PSEL;
    logic          PENABLE;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [NS*DW-1:0] PRDATA;
    logic [NS-1:0] PREADY;
    logic [NS-1:0] PSLVERR;

    int            wait_cfg  [NS];
    logic [DW-1:0] rdata_cfg [NS];
    logic          err_cfg   [NS];
    int            acc_cnt = 0;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    logic [NS-1:0] psel_log    [LOGN];
    logic          penable_log [LOGN];
    logic          pwrite_log  [LOGN];
    logic          rspv_log    [LOGN];
    logic [AW-1:0] paddr_log   [LOGN];
    logic [DW-1:0] pwdata_log  [LOGN];

    apb_bridge_nslv #(
        .NUM_SLAVES (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT    (TO)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PADDR       (PADDR),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    // Slave model: acc_cnt counts ACCESS cycles already spent waiting.
    always @(posedge PCLK) begin
        if (PENABLE && ((PSEL & PREADY) == '0)) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always_comb begin
        PREADY  = '0;
        PSLVERR = '0;
        PRDATA  = '0;
        for (int i = 0; i < NS; i++) begin
            PREADY[i]          = PSEL[i] && PENABLE && (acc_cnt >= wait_cfg[i]);
            PSLVERR[i]         = PREADY[i] && err_cfg[i];
            PRDATA[i*DW +: DW] = rdata_cfg[i];
        end
    end

    always @(negedge PCLK) begin
        if (cyc < LOGN) begin
            psel_log[cyc]    <= PSEL;
            penable_log[cyc] <= PENABLE;
            pwrite_log[cyc]  <= PWRITE;
            rspv_log[cyc]    <= rsp_valid;
            paddr_log[cyc]   <= PADDR;
            pwdata_log[cyc]  <= PWDATA;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit hold, output int acc);
        int n = 0;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        check_eq("cmd_accept", cmd_ready, 1);
        acc = cyc;
        @(posedge PCLK);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int rc);
        int n = 0;
        @(negedge PCLK);
        while (!rsp_valid && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        check_eq("rsp_seen", rsp_valid, 1);
        rc = cyc;
    endtask

    function automatic int count_penable(input int from, input int to);
        int s = 0;
        for (int i = from; i <= to && i < LOGN; i++) s += int'(penable_log[i]);
        return s;
    endfunction

    function automatic logic [NS-1:0] or_psel(input int from, input int to);
        logic [NS-1:0] v = '0;
        for (int i = from; i <= to && i < LOGN; i++) v |= psel_log[i];
        return v;
    endfunction

    function automatic int count_rsp(input int from, input int to);
        int s = 0;
        for (int i = from; i <= to && i < LOGN; i++) s += int'(rspv_log[i]);
        return s;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, r, a0, a1, a2, zero_psel;
        int rc[$];

        for (int i = 0; i < NS; i++) begin
            wait_cfg[i]  = 0;
            rdata_cfg[i] = '0;
            err_cfg[i]   = 1'b0;
        end

        // Reset
        repeat (3) @(negedge PCLK);
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_psel", PSEL, 0);
        check_eq("rst_penable", PENABLE, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_paddr", PADDR, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check_eq("ready_after_reset", cmd_ready, 1);

        // 1: zero-wait write then read on slave 1
        issue(1'b1, 12'h404, 32'hDEADBEEF, 1'b0, a);
        wait_rsp(r);
        check_eq("t1_wr_latency", r - a, 3);
        check_eq("t1_wr_err", rsp_err, 0);
        check_eq("t1_wr_rdata", rsp_rdata, 0);
        check_eq("t1_setup_psel", psel_log[a+1], 3'b010);
        check_eq("t1_setup_penable", penable_log[a+1], 0);
        check_eq("t1_access_penable", penable_log[a+2], 1);
        check_eq("t1_pwrite", pwrite_log[a+1], 1);
        check_eq("t1_paddr", paddr_log[a+1], 12'h404);
        check_eq("t1_pwdata", pwdata_log[a+1], 32'hDEADBEEF);
        @(negedge PCLK);
        check_eq("t1_rsp_one_cycle", rsp_valid, 0);
        rdata_cfg[1] = 32'hDEADBEEF;
        issue(1'b0, 12'h404, 32'h0, 1'b0, a);
        wait_rsp(r);
        check_eq("t1_rd_latency", r - a, 3);
        check_eq("t1_rd_rdata", rsp_rdata, 32'hDEADBEEF);
        check_eq("t1_rd_err", rsp_err, 0);
        check_eq("t1_rd_pwrite", pwrite_log[a+1], 0);
        check_eq("t1_rd_psel", psel_log[a+2], 3'b010);

        // 2: slave 0 with 5 wait states
        wait_cfg[0]  = 5;
        rdata_cfg[0] = 32'h12345678;
        issue(1'b0, 12'h008, 32'h0, 1'b0, a);
        wait_rsp(r);
        check_eq("t2_latency", r - a, 8);
        check_eq("t2_rdata", rsp_rdata, 32'h12345678);
        check_eq("t2_err", rsp_err, 0);
        check_eq("t2_timeout", rsp_timeout, 0);
        repeat (2) @(negedge PCLK);
        check_eq("t2_penable_cycles", count_penable(a, r), 6);
        wait_cfg[0] = 0;

        // 4: unmapped read
        issue(1'b0, 12'hC00, 32'h0, 1'b0, a);
        wait_rsp(r);
        check_eq("t4_latency", r - a, 2);
        check_eq("t4_err", rsp_err, 1);
        check_eq("t4_timeout", rsp_timeout, 0);
        check_eq("t4_rdata", rsp_rdata, 0);
        check_eq("t4_idle_ready", cmd_ready, 1);
        repeat (2) @(negedge PCLK);
        check_eq("t4_psel_quiet", or_psel(a, r + 1), 0);
        check_eq("t4_penable_quiet", count_penable(a, r + 1), 0);

        // 3: back-to-back writes
        issue(1'b1, 12'h000, 32'h11, 1'b1, a0);
        issue(1'b1, 12'h400, 32'h22, 1'b1, a1);
        issue(1'b1, 12'h800, 32'h33, 1'b0, a2);
        repeat (6) @(negedge PCLK);
        for (int i = a0; i <= a2 + 5; i++) if (rspv_log[i]) rc.push_back(i);
        check_eq("t3_rsp_count", rc.size(), 3);
        check_eq("t3_accept_gap1", a1 - a0, 2);
        check_eq("t3_accept_gap2", a2 - a1, 2);
        if (rc.size() >= 3) begin
            check_eq("t3_first_latency", rc[0] - a0, 3);
            check_eq("t3_rsp_gap1", rc[1] - rc[0], 2);
            check_eq("t3_rsp_gap2", rc[2] - rc[1], 2);
        end
        check_eq("t3_psel0", psel_log[a0+1], 3'b001);
        check_eq("t3_psel1", psel_log[a1+1], 3'b010);
        check_eq("t3_psel2", psel_log[a2+1], 3'b100);
        check_eq("t3_setup_penable", penable_log[a1+1], 0);
        check_eq("t3_pwdata1", pwdata_log[a1+1], 32'h22);
        zero_psel = 0;
        for (int i = a0 + 1; i <= a2 + 2; i++) if (psel_log[i] == '0) zero_psel++;
        check_eq("t3_no_idle", zero_psel, 0);

        // 5a: slave 2 never ready -> timeout
        wait_cfg[2]  = 1000;
        rdata_cfg[2] = 32'h55AA55AA;
        issue(1'b0, 12'h800, 32'h0, 1'b0, a);
        wait_rsp(r);
        check_eq("t5a_latency", r - a, 18);
        check_eq("t5a_err", rsp_err, 1);
        check_eq("t5a_timeout", rsp_timeout, 1);
        check_eq("t5a_rdata", rsp_rdata, 0);
        repeat (2) @(negedge PCLK);
        check_eq("t5a_penable_cycles", count_penable(a, r), 16);
        wait_cfg[2] = 0;

        // 5b: PREADY on the 16th ACCESS cycle with PSLVERR
        wait_cfg[1]  = 15;
        err_cfg[1]   = 1'b1;
        rdata_cfg[1] = 32'hCAFEF00D;
        issue(1'b0, 12'h400, 32'h0, 1'b0, a);
        wait_rsp(r);
        check_eq("t5b_latency", r - a, 18);
        check_eq("t5b_err", rsp_err, 1);
        check_eq("t5b_timeout", rsp_timeout, 0);
        check_eq("t5b_rdata", rsp_rdata, 0);
        err_cfg[1] = 1'b0;

        // 6: reset during ACCESS
        wait_cfg[1] = 3;
        issue(1'b0, 12'h400, 32'h0, 1'b0, a);
        @(negedge PCLK);
        @(negedge PCLK);
        check_eq("t6_in_access", PENABLE, 1);
        PRESETn = 1'b0;
        @(negedge PCLK);
        check_eq("t6_rst_psel", PSEL, 0);
        check_eq("t6_rst_penable", PENABLE, 0);
        check_eq("t6_rst_paddr", PADDR, 0);
        check_eq("t6_rst_cmd_ready", cmd_ready, 0);
        check_eq("t6_rst_rsp_valid", rsp_valid, 0);
        PRESETn = 1'b1;
        #1;
        check_eq("t6_ready_after", cmd_ready, 1);
        repeat (6) @(negedge PCLK);
        check_eq("t6_no_rsp", count_rsp(a, cyc - 1), 0);
        wait_cfg[1]  = 0;
        rdata_cfg[1] = 32'h0BADF00D;
        issue(1'b0, 12'h404, 32'h0, 1'b0, a);
        wait_rsp(r);
        check_eq("t6_latency", r - a, 3);
        check_eq("t6_rdata", rsp_rdata, 32'h0BADF00D);
        check_eq("t6_err", rsp_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
